// File: rtl/palette_pkg.sv
// palette_pkg
// Shared definitions for the drawing palette: the 13 RGB565 colour
// constants in index order, palette size / index width, and the state
// encodings of the navigation and commit state machines. Used by the
// selection controller, the menu renderer and the brush datapath.
package palette_pkg;

    localparam int NUM_COLOURS = 13;
    localparam int IDX_W       = 4;

    localparam logic [15:0] COL_BLACK       = 16'h0000;
    localparam logic [15:0] COL_BEIGE       = 16'hF7BB;
    localparam logic [15:0] COL_ORANGE      = 16'hFD20;
    localparam logic [15:0] COL_BROWN       = 16'hA145;
    localparam logic [15:0] COL_RED         = 16'hF800;
    localparam logic [15:0] COL_PURPLE      = 16'h8010;
    localparam logic [15:0] COL_TURQUOISE   = 16'h471A;
    localparam logic [15:0] COL_BLUE        = 16'h001F;
    localparam logic [15:0] COL_GREEN       = 16'h07E0;
    localparam logic [15:0] COL_LIGHT_GREEN = 16'h9772;
    localparam logic [15:0] COL_YELLOW      = 16'hFFE0;
    localparam logic [15:0] COL_DARK_GREY   = 16'h7BEF;
    localparam logic [15:0] COL_GREY        = 16'hBDF7;

    typedef enum logic [2:0] {
        NAV_IDLE,
        NAV_DEBOUNCE,
        NAV_HOLD,
        NAV_REPEAT,
        NAV_RELEASE
    } nav_state_t;

    typedef enum logic [1:0] {
        CMT_IDLE,
        CMT_DEBOUNCE,
        CMT_RELEASE
    } commit_state_t;

endpackage

// File: rtl/palette_rom.sv
// palette_rom
// Combinational palette lookup: 4-bit index -> RGB565 colour.
// Indices beyond the last palette entry return BLACK.
// Ports:
//   index  in   palette index
//   colour out  RGB565 colour of index
module palette_rom
    import palette_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      colour
);

    always_comb begin
        colour = COL_BLACK;
        case (index)
            4'd0:    colour = COL_BLACK;
            4'd1:    colour = COL_BEIGE;
            4'd2:    colour = COL_ORANGE;
            4'd3:    colour = COL_BROWN;
            4'd4:    colour = COL_RED;
            4'd5:    colour = COL_PURPLE;
            4'd6:    colour = COL_TURQUOISE;
            4'd7:    colour = COL_BLUE;
            4'd8:    colour = COL_GREEN;
            4'd9:    colour = COL_LIGHT_GREEN;
            4'd10:   colour = COL_YELLOW;
            4'd11:   colour = COL_DARK_GREY;
            4'd12:   colour = COL_GREY;
            default: colour = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/palette_select_ctrl.sv
// palette_select_ctrl
// Turns raw btnL/btnR/btnC presses into debounced, auto-repeating palette
// index steps and a commit pulse.
// Ports:
//   CLOCK             in   system clock
//   rst_n             in   asynchronous active-low reset
//   enable            in   palette navigation enabled (level)
//   btnL, btnR, btnC  in   raw asynchronous pushbuttons, active-high
//   sel_index         out  current palette index (registered)
//   selected_colour   out  RGB565 of sel_index (registered)
//   sel_changed       out  one-cycle pulse on every index change
//   commit            out  one-cycle pulse on a debounced btnC press
//   committed_colour  out  colour latched at the last commit
module palette_select_ctrl
    import palette_pkg::*;
#(
    parameter int NUM_COLOURS     = palette_pkg::NUM_COLOURS,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 12_500_000,
    parameter bit WRAP            = 1'b0
) (
    input  logic             CLOCK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             btnC,
    output logic [IDX_W-1:0] sel_index,
    output logic [15:0]      selected_colour,
    output logic             sel_changed,
    output logic             commit,
    output logic [15:0]      committed_colour
);

    localparam int NAV_MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int NAV_MAX    = (NAV_MAX_A > REPEAT_PERIOD) ? NAV_MAX_A : REPEAT_PERIOD;
    localparam int NAV_CNT_W  = $clog2(NAV_MAX + 1);
    localparam int CMT_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLOURS - 1);

    // Two-flop synchronisers, bit order {C, R, L}
    logic [2:0] sync_meta_reg;
    logic [2:0] sync_reg;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= {btnC, btnR, btnL};
            sync_reg      <= sync_meta_reg;
        end
    end

    logic l_sync, r_sync, c_sync;
    assign l_sync = sync_reg[0];
    assign r_sync = sync_reg[1];
    assign c_sync = sync_reg[2];

    // ---------------- navigation FSM ----------------
    nav_state_t           nav_state_reg, nav_state_next;
    logic [NAV_CNT_W-1:0] nav_cnt_reg, nav_cnt_next;
    logic                 dir_reg, dir_next;     // 1 = right (+1), 0 = left (-1)
    logic                 step;
    logic                 held, other;

    assign held  = dir_reg ? r_sync : l_sync;
    assign other = dir_reg ? l_sync : r_sync;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            nav_state_reg <= NAV_IDLE;
            nav_cnt_reg   <= '0;
            dir_reg       <= 1'b0;
        end else begin
            nav_state_reg <= nav_state_next;
            nav_cnt_reg   <= nav_cnt_next;
            dir_reg       <= dir_next;
        end
    end

    always_comb begin
        nav_state_next = nav_state_reg;
        nav_cnt_next   = nav_cnt_reg;
        dir_next       = dir_reg;
        step           = 1'b0;
        if (!enable) begin
            nav_state_next = NAV_IDLE;
            nav_cnt_next   = '0;
        end else begin
            case (nav_state_reg)
                NAV_IDLE: begin
                    nav_cnt_next = '0;
                    // both buttons together are ignored
                    if (l_sync ^ r_sync) begin
                        nav_state_next = NAV_DEBOUNCE;
                        dir_next       = r_sync;
                    end
                end
                NAV_DEBOUNCE: begin
                    if (!held || other) begin
                        nav_state_next = NAV_IDLE;
                        nav_cnt_next   = '0;
                    end else if (nav_cnt_reg == NAV_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        step           = 1'b1;
                        nav_state_next = NAV_HOLD;
                        nav_cnt_next   = '0;
                    end else begin
                        nav_cnt_next = nav_cnt_reg + NAV_CNT_W'(1);
                    end
                end
                NAV_HOLD: begin
                    if (!held) begin
                        nav_state_next = NAV_RELEASE;
                        nav_cnt_next   = '0;
                    end else if (nav_cnt_reg == NAV_CNT_W'(REPEAT_DELAY - 1)) begin
                        step           = 1'b1;
                        nav_state_next = NAV_REPEAT;
                        nav_cnt_next   = '0;
                    end else begin
                        nav_cnt_next = nav_cnt_reg + NAV_CNT_W'(1);
                    end
                end
                NAV_REPEAT: begin
                    if (!held) begin
                        nav_state_next = NAV_RELEASE;
                        nav_cnt_next   = '0;
                    end else if (nav_cnt_reg == NAV_CNT_W'(REPEAT_PERIOD - 1)) begin
                        step         = 1'b1;
                        nav_cnt_next = '0;
                    end else begin
                        nav_cnt_next = nav_cnt_reg + NAV_CNT_W'(1);
                    end
                end
                NAV_RELEASE: begin
                    // both direction buttons must stay low for a full debounce window
                    if (l_sync || r_sync) begin
                        nav_cnt_next = '0;
                    end else if (nav_cnt_reg == NAV_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        nav_state_next = NAV_IDLE;
                        nav_cnt_next   = '0;
                    end else begin
                        nav_cnt_next = nav_cnt_reg + NAV_CNT_W'(1);
                    end
                end
                default: begin
                    nav_state_next = NAV_IDLE;
                    nav_cnt_next   = '0;
                end
            endcase
        end
    end

    // ---------------- index datapath ----------------
    logic [IDX_W-1:0] idx_next;
    logic [15:0]      colour_next;
    logic [IDX_W-1:0] sel_index_reg;
    logic [15:0]      selected_colour_reg;
    logic             sel_changed_reg;

    always_comb begin
        idx_next = sel_index_reg;
        if (step) begin
            if (dir_reg) begin
                if (sel_index_reg == LAST_IDX) idx_next = WRAP ? '0 : sel_index_reg;
                else                           idx_next = sel_index_reg + IDX_W'(1);
            end else begin
                if (sel_index_reg == '0) idx_next = WRAP ? LAST_IDX : sel_index_reg;
                else                     idx_next = sel_index_reg - IDX_W'(1);
            end
        end
    end

    // colour register is fed from the next index so both update together
    palette_rom u_rom (
        .index  (idx_next),
        .colour (colour_next)
    );

    // ---------------- commit debouncer ----------------
    commit_state_t        cmt_state_reg, cmt_state_next;
    logic [CMT_CNT_W-1:0] cmt_cnt_reg, cmt_cnt_next;
    logic                 fire;
    logic                 commit_reg;
    logic [15:0]          committed_colour_reg;

    always_comb begin
        cmt_state_next = cmt_state_reg;
        cmt_cnt_next   = cmt_cnt_reg;
        fire           = 1'b0;
        if (!enable) begin
            cmt_state_next = CMT_IDLE;
            cmt_cnt_next   = '0;
        end else begin
            case (cmt_state_reg)
                CMT_IDLE: begin
                    cmt_cnt_next = '0;
                    if (c_sync) cmt_state_next = CMT_DEBOUNCE;
                end
                CMT_DEBOUNCE: begin
                    if (!c_sync) begin
                        cmt_state_next = CMT_IDLE;
                        cmt_cnt_next   = '0;
                    end else if (cmt_cnt_reg == CMT_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        fire           = 1'b1;
                        cmt_state_next = CMT_RELEASE;
                        cmt_cnt_next   = '0;
                    end else begin
                        cmt_cnt_next = cmt_cnt_reg + CMT_CNT_W'(1);
                    end
                end
                CMT_RELEASE: begin
                    if (c_sync) begin
                        cmt_cnt_next = '0;
                    end else if (cmt_cnt_reg == CMT_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cmt_state_next = CMT_IDLE;
                        cmt_cnt_next   = '0;
                    end else begin
                        cmt_cnt_next = cmt_cnt_reg + CMT_CNT_W'(1);
                    end
                end
                default: begin
                    cmt_state_next = CMT_IDLE;
                    cmt_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            sel_index_reg        <= '0;
            selected_colour_reg  <= COL_BLACK;
            sel_changed_reg      <= 1'b0;
            cmt_state_reg        <= CMT_IDLE;
            cmt_cnt_reg          <= '0;
            commit_reg           <= 1'b0;
            committed_colour_reg <= COL_BLACK;
        end else begin
            sel_index_reg       <= idx_next;
            selected_colour_reg <= colour_next;
            sel_changed_reg     <= (idx_next != sel_index_reg);
            cmt_state_reg       <= cmt_state_next;
            cmt_cnt_reg         <= cmt_cnt_next;
            commit_reg          <= fire;
            // uses the current (pre-step) colour when a step lands on the same edge
            if (fire) committed_colour_reg <= selected_colour_reg;
        end
    end

    assign sel_index        = sel_index_reg;
    assign selected_colour  = selected_colour_reg;
    assign sel_changed      = sel_changed_reg;
    assign commit           = commit_reg;
    assign committed_colour = committed_colour_reg;

endmodule

// File: tb/tb_palette_select_ctrl.sv
// Directed bench for palette_select_ctrl. Two instances share stimulus:
// dut_a saturates at the ends, dut_b wraps.
module tb_palette_select_ctrl;

    localparam logic [15:0] BLACK     = 16'h0000;
    localparam logic [15:0] BEIGE     = 16'hF7BB;
    localparam logic [15:0] RED       = 16'hF800;
    localparam logic [15:0] PURPLE    = 16'h8010;
    localparam logic [15:0] TURQUOISE = 16'h471A;
    localparam logic [15:0] DARK_GREY = 16'h7BEF;
    localparam logic [15:0] GREY      = 16'hBDF7;

    logic        CLOCK = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        btnL, btnR, btnC;
    logic [3:0]  idx_a, idx_b;
    logic [15:0] col_a, col_b;
    logic        chg_a, chg_b;
    logic        com_a, com_b;
    logic [15:0] ccol_a, ccol_b;

    int n_cmp = 0;
    int n_err = 0;
    int edge_no;
    logic [127:0] chg_mask_a, chg_mask_b, com_mask_a;

    always #5 CLOCK = ~CLOCK;

    palette_select_ctrl #(
        .DEBOUNCE_CYCLES (4), .REPEAT_DELAY (20), .REPEAT_PERIOD (8), .WRAP (1'b0)
    ) dut_a (
        .CLOCK (CLOCK), .rst_n (rst_n), .enable (enable),
        .btnL (btnL), .btnR (btnR), .btnC (btnC),
        .sel_index (idx_a), .selected_colour (col_a), .sel_changed (chg_a),
        .commit (com_a), .committed_colour (ccol_a)
    );

    palette_select_ctrl #(
        .DEBOUNCE_CYCLES (4), .REPEAT_DELAY (20), .REPEAT_PERIOD (8), .WRAP (1'b1)
    ) dut_b (
        .CLOCK (CLOCK), .rst_n (rst_n), .enable (enable),
        .btnL (btnL), .btnR (btnR), .btnC (btnC),
        .sel_index (idx_b), .selected_colour (col_b), .sel_changed (chg_b),
        .commit (com_b), .committed_colour (ccol_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_phase();
        edge_no    = 0;
        chg_mask_a = '0;
        chg_mask_b = '0;
        com_mask_a = '0;
    endtask

    // advance n clock edges, sampling 1 time unit after each rising edge;
    // bit k of each mask is the pulse seen after edge k of the phase
    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
            edge_no++;
            if (edge_no < 128) begin
                chg_mask_a[edge_no] = chg_a;
                chg_mask_b[edge_no] = chg_b;
                com_mask_a[edge_no] = com_a;
            end
        end
    endtask

    task automatic press(input logic l, input logic r, input int n);
        btnL = l; btnR = r;
        run(n);
        btnL = 1'b0; btnR = 1'b0;
        run(12);
    endtask

    logic [127:0] one;

    initial begin
        one    = 128'd1;
        rst_n  = 1'b0;
        enable = 1'b1;
        btnL   = 1'b0; btnR = 1'b0; btnC = 1'b0;
        begin_phase();
        run(3);
        chk("reset_idx", idx_a, 4'd0);
        chk("reset_colour", col_a, BLACK);
        chk("reset_changed", chg_a, 1'b0);
        chk("reset_commit", com_a, 1'b0);
        chk("reset_ccol", ccol_a, BLACK);
        rst_n = 1'b1;
        run(3);

        // single press from 0
        begin_phase();
        press(1'b0, 1'b1, 10);
        chk("single_mask", chg_mask_a, one << 7);
        chk("single_idx", idx_a, 4'd1);
        chk("single_colour", col_a, BEIGE);

        // asynchronous reset mid-press, then release with btnR still held
        btnR = 1'b1;
        run(5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_idx", idx_a, 4'd0);
        chk("async_rst_colour", col_a, BLACK);
        run(2);
        rst_n = 1'b1;
        begin_phase();
        run(10);
        btnR = 1'b0;
        run(12);
        chk("rst_release_mask", chg_mask_a, one << 7);
        chk("rst_release_idx", idx_a, 4'd1);

        // bounce shorter than debounce window
        begin_phase();
        btnR = 1'b1; run(3);
        btnR = 1'b0; run(1);
        btnR = 1'b1; run(3);
        btnR = 1'b0; run(12);
        chk("bounce_mask", chg_mask_a, 128'd0);
        chk("bounce_idx", idx_a, 4'd1);

        begin_phase();
        btnC = 1'b1; run(2);
        btnC = 1'b0; run(12);
        chk("glitch_commit_mask", com_mask_a, 128'd0);
        chk("glitch_ccol", ccol_a, BLACK);

        // back to 0, then auto-repeat
        press(1'b1, 1'b0, 10);
        chk("left_to_0", idx_a, 4'd0);
        begin_phase();
        press(1'b0, 1'b1, 60);
        chk("repeat_mask", chg_mask_a,
            (one << 7) | (one << 27) | (one << 35) | (one << 43) | (one << 51) | (one << 59));
        chk("repeat_idx", idx_a, 4'd6);
        chk("repeat_colour", col_a, TURQUOISE);

        // commit at index 4, button held long
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        chk("idx_before_commit", idx_a, 4'd4);
        begin_phase();
        btnC = 1'b1; run(50);
        btnC = 1'b0; run(12);
        chk("commit_mask", com_mask_a, one << 7);
        chk("commit_ccol", ccol_a, RED);
        chk("commit_no_step", chg_mask_a, 128'd0);

        // L and R together
        begin_phase();
        press(1'b1, 1'b1, 10);
        chk("both_mask", chg_mask_a, 128'd0);
        chk("both_idx", idx_a, 4'd4);

        // enable dropped during HOLD
        begin_phase();
        btnR = 1'b1; run(12);
        enable = 1'b0; run(28);
        btnR = 1'b0; run(12);
        enable = 1'b1; run(2);
        chk("enable_drop_mask", chg_mask_a, one << 7);
        chk("enable_drop_idx", idx_a, 4'd5);
        chk("enable_drop_colour", col_a, PURPLE);

        // climb 5 -> 12 with auto-repeat (7 steps by edge 67)
        press(1'b0, 1'b1, 70);
        chk("climb_idx_a", idx_a, 4'd12);
        chk("climb_idx_b", idx_b, 4'd12);
        chk("climb_colour", col_a, GREY);

        // upper bound: saturate vs wrap
        begin_phase();
        press(1'b0, 1'b1, 10);
        chk("sat_mask", chg_mask_a, 128'd0);
        chk("sat_idx", idx_a, 4'd12);
        chk("wrap_mask", chg_mask_b, one << 7);
        chk("wrap_idx", idx_b, 4'd0);
        chk("wrap_colour", col_b, BLACK);

        // lower bound wrap on dut_b, plain step on dut_a
        begin_phase();
        press(1'b1, 1'b0, 10);
        chk("wrap_low_idx", idx_b, 4'd12);
        chk("wrap_low_mask", chg_mask_b, one << 7);
        chk("left_step_idx_a", idx_a, 4'd11);

        // commit and step on the same edge take the pre-step colour
        begin_phase();
        btnC = 1'b1; btnR = 1'b1; run(10);
        btnC = 1'b0; btnR = 1'b0; run(12);
        chk("same_edge_commit", com_mask_a, one << 7);
        chk("same_edge_step", chg_mask_a, one << 7);
        chk("same_edge_idx", idx_a, 4'd12);
        chk("same_edge_ccol_a", ccol_a, DARK_GREY);
        chk("same_edge_ccol_b", ccol_b, GREY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
